// File: rtl/wb_pkg.sv
// Shared widths, constants and the load-entry type for the writeback arbiter slice.
package wb_pkg;
  localparam int REG_W    = 4;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam logic [REG_W-1:0] ZERO_REG = 4'd0;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } ld_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_W-1:0] r);
    reg_mask = {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
  endfunction
endpackage

// File: rtl/wb_write_arbiter_if.sv
// ALU/load result streams in, register-file write port out.
interface wb_write_arbiter_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic [REG_W-1:0]  alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [REG_W-1:0]  ld_reg;
  logic [DATA_W-1:0] ld_data;
  logic [REG_W-1:0]  DstReg;
  logic              WriteReg;
  logic [DATA_W-1:0] DstData;
  logic              wb_src;

  modport master (
    output alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
    input  ld_ready, DstReg, WriteReg, DstData, wb_src
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data, ld_valid, ld_reg, ld_data,
    output ld_ready, DstReg, WriteReg, DstData, wb_src
  );
endinterface

// File: rtl/wb_write_arbiter_chk.sv
// Simulation-only protocol checks for the writeback arbiter.
module wb_write_arbiter_chk (
  input logic        clk,
  input logic        rst,
  input logic        alu_valid,
  input logic [3:0]  alu_reg,
  input logic        ld_valid,
  input logic [3:0]  ld_reg,
  input logic [15:0] pending,
  input logic        WriteReg,
  input logic [3:0]  DstReg
);
  a_ld_to_pending: assert property (@(posedge clk) disable iff (!rst)
    !(ld_valid && pending[ld_reg]));
  a_alu_to_pending: assert property (@(posedge clk) disable iff (!rst)
    !(alu_valid && pending[alu_reg]));
  a_no_r0_write: assert property (@(posedge clk) disable iff (!rst)
    !(WriteReg && (DstReg == 4'd0)));
endmodule

// File: rtl/wb_write_arbiter_load_fifo.sv
// wb_load_fifo: in-order circular buffer of pending load results; LD_DEPTH must be a power of two.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  ld_entry_t i_entry,
  input  logic      i_pop,
  output ld_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);
  localparam int PTR_W = $clog2(LD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ld_entry_t        r_mem [LD_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(LD_DEPTH));
  assign o_empty   = (r_count == {CNT_W{1'b0}});
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      else           r_wr_ptr <= r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      else           r_rd_ptr <= r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
  end
endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file writeback arbiter: ALU has absolute priority, queued loads drain in idle slots.
// Optional WB_STALL_CNT_EN adds a saturating count of slots the ALU took from waiting loads.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  wb_write_arbiter_if.slave   bus,
  output logic [NUM_REGS-1:0] pending
`ifdef WB_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);
  logic                r_we;
  logic [REG_W-1:0]    r_dst_reg;
  logic [DATA_W-1:0]   r_dst_data;
  logic                r_wb_src;
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_pending_nxt;
  logic                w_alu_win;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  ld_entry_t           w_head;
  ld_entry_t           w_entry;

  // An ALU write aimed at R0 is treated as an idle slot.
  assign w_alu_win    = bus.alu_valid && (bus.alu_reg != ZERO_REG);
  assign w_pop        = !w_alu_win && !w_empty;
  assign bus.ld_ready = rst && !w_full;
  assign w_push       = bus.ld_valid && bus.ld_ready && (bus.ld_reg != ZERO_REG);
  assign w_entry      = '{rd: bus.ld_reg, data: bus.ld_data};

  wb_load_fifo #(.LD_DEPTH(LD_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Scoreboard: clear on pop into the output register, set on enqueue.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) w_pending_nxt = w_pending_nxt & ~reg_mask(w_head.rd);
    else       w_pending_nxt = w_pending_nxt;
    if (w_push) w_pending_nxt = w_pending_nxt | reg_mask(bus.ld_reg);
    else        w_pending_nxt = w_pending_nxt;
  end

  // Output register: ALU, then FIFO head, else idle with address/data held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we       <= 1'b0;
      r_dst_reg  <= ZERO_REG;
      r_dst_data <= {DATA_W{1'b0}};
      r_wb_src   <= 1'b0;
      r_pending  <= {NUM_REGS{1'b0}};
    end else begin
      if (w_alu_win) begin
        r_we       <= 1'b1;
        r_dst_reg  <= bus.alu_reg;
        r_dst_data <= bus.alu_data;
        r_wb_src   <= 1'b0;
      end else if (w_pop) begin
        r_we       <= 1'b1;
        r_dst_reg  <= w_head.rd;
        r_dst_data <= w_head.data;
        r_wb_src   <= 1'b1;
      end else begin
        r_we       <= 1'b0;
      end
      r_pending <= w_pending_nxt;
    end
  end

  assign bus.WriteReg = r_we;
  assign bus.DstReg   = r_dst_reg;
  assign bus.DstData  = r_dst_data;
  assign bus.wb_src   = r_wb_src;
  assign pending      = r_pending;

`ifdef WB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  // Saturating count of slots the ALU won while loads were waiting.
  always_ff @(posedge clk) begin
    if (!rst) r_stall_cnt <= 16'd0;
    else if (w_alu_win && !w_empty && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
    else r_stall_cnt <= r_stall_cnt;
  end

  assign stall_cnt = r_stall_cnt;
`endif

  wb_write_arbiter_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (bus.alu_valid),
    .alu_reg   (bus.alu_reg),
    .ld_valid  (bus.ld_valid),
    .ld_reg    (bus.ld_reg),
    .pending   (r_pending),
    .WriteReg  (r_we),
    .DstReg    (r_dst_reg)
  );
endmodule
